ext_trigger_ctrl: RTL and testbench

EXT_TRIGGER_CTRL -- requirements
Module: ext_trigger_ctrl

---
 rtl/ext_trigger_ctrl.sv | 121 ++++++++++++
 tb/tb_ext_trigger_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ext_trigger_ctrl.sv
// External trigger controller: arms on request, turns pulse/software events into a
// delayed one-cycle trigger with holdoff dead-time, per-arm limit and event statistics.
module ext_trigger_ctrl #(
  parameter int DLY_W = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pulse_in,
  input  logic             arm,
  input  logic             disarm,
  input  logic             sw_trigger,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [15:0]      cfg_holdoff,
  input  logic [15:0]      cfg_count,
  output logic             trigger_out,
  output logic             armed,
  output logic [31:0]      trigger_count,
  output logic [15:0]      missed_count,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_FIRE    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t           state, state_next;
  logic             pulse_q;
  logic [DLY_W-1:0] delay_q;
  logic [15:0]      holdoff_q;
  logic [15:0]      count_q;
  logic [DLY_W-1:0] dly_cnt;
  logic [15:0]      hold_cnt;
  logic [15:0]      fire_cnt;
  logic [15:0]      fire_cnt_inc;
  logic             event_hit;
  logic             fire;
  logic             busy;
  logic             arm_accept;

  assign event_hit    = (pulse_in & ~pulse_q) | sw_trigger;
  // disarm suppresses the trigger even in the FIRE cycle itself
  assign fire         = (state == S_FIRE) && !disarm;
  assign busy         = (state == S_DELAY) || (state == S_FIRE) || (state == S_HOLDOFF);
  assign arm_accept   = (state == S_IDLE) && arm && !disarm;
  assign fire_cnt_inc = fire_cnt + 16'd1;

  assign trigger_out  = fire;
  assign armed        = (state != S_IDLE);
  assign fsm_state    = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (arm) state_next = S_ARMED;
      S_ARMED:   if (event_hit) state_next = (delay_q == '0) ? S_FIRE : S_DELAY;
      S_DELAY:   if (dly_cnt == '0) state_next = S_FIRE;
      S_FIRE: begin
        if ((count_q != 16'd0) && (fire_cnt_inc == count_q)) state_next = S_IDLE;
        else if (holdoff_q == 16'd0)                          state_next = S_ARMED;
        else                                                  state_next = S_HOLDOFF;
      end
      S_HOLDOFF: if (hold_cnt == 16'd0) state_next = S_ARMED;
      default:   state_next = S_IDLE;
    endcase
    if (disarm) state_next = S_IDLE;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pulse_q   <= 1'b0;
      delay_q   <= '0;
      holdoff_q <= 16'd0;
      count_q   <= 16'd0;
      fire_cnt  <= 16'd0;
    end else begin
      pulse_q <= pulse_in;
      if (arm_accept) begin
        delay_q   <= cfg_delay;
        holdoff_q <= cfg_holdoff;
        count_q   <= cfg_count;
        fire_cnt  <= 16'd0;
      end else if (fire) begin
        fire_cnt <= fire_cnt_inc;
      end
    end
  end

  // Timers are loaded with N-1 so DELAY/HOLDOFF occupy exactly N cycles.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dly_cnt  <= '0;
      hold_cnt <= 16'd0;
    end else begin
      if ((state == S_ARMED) && (state_next == S_DELAY)) dly_cnt <= delay_q - 1'b1;
      else if ((state == S_DELAY) && (dly_cnt != '0))    dly_cnt <= dly_cnt - 1'b1;
      if ((state == S_FIRE) && (state_next == S_HOLDOFF)) hold_cnt <= holdoff_q - 16'd1;
      else if ((state == S_HOLDOFF) && (hold_cnt != 16'd0)) hold_cnt <= hold_cnt - 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      trigger_count <= 32'd0;
      missed_count  <= 16'd0;
    end else begin
      if (fire) trigger_count <= trigger_count + 32'd1;
      if (event_hit && busy && !disarm && (missed_count != 16'hFFFF))
        missed_count <= missed_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ext_trigger_ctrl.sv
// Bench for ext_trigger_ctrl: per-cycle vector table plus hand-written sequences
// for reset during DELAY and missed-count saturation.
module tb_ext_trigger_ctrl;
  localparam int DLY_W = 32;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             pulse_in = 1'b0;
  logic             arm = 1'b0;
  logic             disarm = 1'b0;
  logic             sw_trigger = 1'b0;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic [15:0]      cfg_holdoff = 16'd0;
  logic [15:0]      cfg_count = 16'd0;
  logic             trigger_out;
  logic             armed;
  logic [31:0]      trigger_count;
  logic [15:0]      missed_count;
  logic [2:0]       fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic             a, d, p, s;
    logic [DLY_W-1:0] dly;
    logic [15:0]      hold, cnt;
    logic             trig, armd;
    logic [31:0]      tcnt;
    logic [15:0]      miss;
  } vec_t;

  vec_t tbl[$];
  logic [DLY_W-1:0] c_dly;
  logic [15:0]      c_hold, c_cnt;
  logic [31:0]      e_tcnt;
  logic [15:0]      e_miss;

  ext_trigger_ctrl #(.DLY_W(DLY_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .pulse_in(pulse_in), .arm(arm), .disarm(disarm),
    .sw_trigger(sw_trigger), .cfg_delay(cfg_delay), .cfg_holdoff(cfg_holdoff),
    .cfg_count(cfg_count), .trigger_out(trigger_out), .armed(armed),
    .trigger_count(trigger_count), .missed_count(missed_count), .fsm_state(fsm_state)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic a, input logic d, input logic p, input logic s,
                     input logic trig, input logic armd, input int reps = 1);
    vec_t v;
    v.a = a; v.d = d; v.p = p; v.s = s;
    v.dly = c_dly; v.hold = c_hold; v.cnt = c_cnt;
    v.trig = trig; v.armd = armd; v.tcnt = e_tcnt; v.miss = e_miss;
    for (int r = 0; r < reps; r++) tbl.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic build_table();
    e_tcnt = 0; e_miss = 0;
    // delay 0 / holdoff 5 / unlimited; config changed after arming must not matter
    c_dly = 0; c_hold = 5; c_cnt = 0;
    add(1,0,0,0, 0,0);
    c_dly = 7; c_hold = 0; c_cnt = 2;
    add(0,0,0,0, 0,1);
    add(0,0,1,0, 0,1);
    add(0,0,1,0, 1,1);
    e_tcnt = 1;
    add(0,0,0,0, 0,1);
    add(0,0,0,1, 0,1);
    e_miss = 1;
    add(0,0,0,0, 0,1, 3);
    add(0,0,1,0, 0,1);
    add(0,0,0,0, 1,1);
    e_tcnt = 2;
    add(0,0,0,0, 0,1, 5);
    add(0,1,1,0, 0,1);
    add(0,0,0,0, 0,0);
    add(0,0,1,0, 0,0);
    add(0,0,0,0, 0,0);
    // per-arm limit of 3, events every 4 cycles
    c_dly = 0; c_hold = 0; c_cnt = 3;
    add(1,0,0,0, 0,0);
    add(0,0,1,0, 0,1);
    add(0,0,0,0, 1,1);
    e_tcnt = 3;
    add(0,0,0,0, 0,1, 2);
    add(0,0,1,0, 0,1);
    add(0,0,0,0, 1,1);
    e_tcnt = 4;
    add(0,0,0,0, 0,1, 2);
    add(0,0,1,0, 0,1);
    add(0,0,0,0, 1,1);
    e_tcnt = 5;
    add(0,0,0,0, 0,0, 2);
    add(0,0,1,0, 0,0);
    add(0,0,0,0, 0,0, 2);
    // sw_trigger, delay 10, count 1; arm in DELAY ignored; misses in DELAY and FIRE
    c_dly = 10; c_hold = 0; c_cnt = 1;
    add(1,0,0,0, 0,0);
    c_dly = 0; c_cnt = 0;
    add(0,0,0,0, 0,1);
    add(0,0,0,1, 0,1);
    add(0,0,0,0, 0,1, 2);
    add(1,0,0,0, 0,1);
    add(0,0,0,0, 0,1);
    add(0,0,1,0, 0,1);
    e_miss = 2;
    add(0,0,0,0, 0,1, 5);
    add(0,0,0,1, 1,1);
    e_tcnt = 6; e_miss = 3;
    add(0,0,0,0, 0,0, 2);
    // disarm mid-DELAY
    c_dly = 10; c_hold = 0; c_cnt = 1;
    add(1,0,0,0, 0,0);
    add(0,0,0,0, 0,1);
    add(0,0,1,0, 0,1);
    add(0,0,0,0, 0,1, 2);
    add(0,1,0,0, 0,1);
    add(0,0,0,0, 0,0, 12);
    // disarm in the FIRE cycle itself
    c_dly = 0; c_hold = 0; c_cnt = 0;
    add(1,0,0,0, 0,0);
    add(0,0,0,0, 0,1);
    add(0,0,1,0, 0,1);
    add(0,1,0,0, 0,1);
    add(0,0,0,0, 0,0, 3);
  endtask

  initial begin
    int hits;
    build_table();

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset trig", {31'd0, trigger_out}, 32'd0);
    chk("reset armed", {31'd0, armed}, 32'd0);
    chk("reset tcount", trigger_count, 32'd0);
    chk("reset missed", {16'd0, missed_count}, 32'd0);
    chk("reset state", {29'd0, fsm_state}, 32'd0);
    aresetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      next_cycle();
      arm = tbl[i].a; disarm = tbl[i].d; pulse_in = tbl[i].p; sw_trigger = tbl[i].s;
      cfg_delay = tbl[i].dly; cfg_holdoff = tbl[i].hold; cfg_count = tbl[i].cnt;
      @(negedge aclk);
      chk($sformatf("row%0d trig", i), {31'd0, trigger_out}, {31'd0, tbl[i].trig});
      chk($sformatf("row%0d armed", i), {31'd0, armed}, {31'd0, tbl[i].armd});
      chk($sformatf("row%0d tcount", i), trigger_count, tbl[i].tcnt);
      chk($sformatf("row%0d missed", i), {16'd0, missed_count}, {16'd0, tbl[i].miss});
    end
    next_cycle();
    arm = 0; disarm = 0; pulse_in = 0; sw_trigger = 0;

    // reset asserted while a 100-cycle delay is pending
    cfg_delay = 100; cfg_holdoff = 0; cfg_count = 0;
    arm = 1; next_cycle(); arm = 0;
    pulse_in = 1; next_cycle(); pulse_in = 0;
    repeat (20) next_cycle();
    @(negedge aclk);
    chk("mid-delay armed", {31'd0, armed}, 32'd1);
    aresetn = 1'b0;
    #1;
    chk("async reset armed", {31'd0, armed}, 32'd0);
    chk("async reset tcount", trigger_count, 32'd0);
    chk("async reset missed", {16'd0, missed_count}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    hits = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge aclk);
      if (trigger_out) hits++;
    end
    chk("post-reset trigger count", hits, 0);
    chk("post-reset state", {29'd0, fsm_state}, 32'd0);
    chk("post-reset tcount", trigger_count, 32'd0);

    // missed_count saturation with sw_trigger held during a long delay
    next_cycle();
    cfg_delay = 32'h30000;
    arm = 1; next_cycle(); arm = 0;
    sw_trigger = 1;
    repeat (65535) next_cycle();
    sw_trigger = 0;
    @(negedge aclk);
    chk("missed 0xFFFE", {16'd0, missed_count}, 32'h0000FFFE);
    next_cycle();
    sw_trigger = 1;
    repeat (3) next_cycle();
    sw_trigger = 0;
    @(negedge aclk);
    chk("missed saturated", {16'd0, missed_count}, 32'h0000FFFF);
    chk("sat no trigger", trigger_count, 32'd0);
    chk("sat still armed", {31'd0, armed}, 32'd1);
    next_cycle();
    disarm = 1; next_cycle(); disarm = 0;
    @(negedge aclk);
    chk("final disarm", {31'd0, armed}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
